refresh_scheduler: RTL

Sequences the refresh-by-copy rounds of a group of gain-cell DRAM bank wrappers (128x64 each, one physical spare). A retention timer periodically selects the next source bank and copies it, row by row, into the current spare through the wrappers' self-refresh shift register. On completion the source becomes the new spare. The block sits between the top-level controller and the bank wrappers and drives their `start_SR`, `ref_en_current` and `ref_en_old` inputs.

---
 rtl/refresh_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/refresh_scheduler.sv
// Refresh-by-copy round sequencer for a group of gain-cell DRAM bank wrappers.
// A retention timer (or a forced request) copies the next source bank into the spare, which then rotates.
module refresh_scheduler #(
  parameter int NUM_BANKS  = 4,
  parameter int RET_CYCLES = 1024,
  parameter int TIMEOUT    = 512,
  parameter int IDX_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 force_ref,
  input  logic [NUM_BANKS-1:0] ref_done,
  output logic [NUM_BANKS-1:0] start_SR,
  output logic [NUM_BANKS-1:0] ref_en_current,
  output logic [NUM_BANKS-1:0] ref_en_old,
  output logic [IDX_W-1:0]     spare_idx,
  output logic [IDX_W-1:0]     src_idx,
  output logic                 busy,
  output logic                 swap,
  output logic                 err
);

  localparam int TMR_W = $clog2(RET_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(RET_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    COPY  = 2'd2,
    SWAP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [TMR_W-1:0]   timer_r;
  logic [WD_W-1:0]    wd_r;
  logic               round_go_s;
  logic               done_s;
  logic [IDX_W-1:0]   next_src_s;

  function automatic logic [NUM_BANKS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign round_go_s = force_ref | (en & (timer_r == {TMR_W{1'b0}}));
  assign done_s     = ref_done[src_idx];
  // The next source follows the new spare (the current source), so it can never collide with it.
  assign next_src_s = (src_idx == IDX_LAST) ? {IDX_W{1'b0}} : src_idx + IDX_W'(1);

  // Round FSM with all outputs registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= IDLE;
      timer_r        <= TMR_RELOAD;
      wd_r           <= {WD_W{1'b0}};
      spare_idx      <= IDX_LAST;
      src_idx        <= {IDX_W{1'b0}};
      start_SR       <= {NUM_BANKS{1'b0}};
      ref_en_current <= {NUM_BANKS{1'b0}};
      ref_en_old     <= {NUM_BANKS{1'b0}};
      busy           <= 1'b0;
      swap           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (round_go_s) begin
            state_r        <= START;
            start_SR       <= onehot(src_idx);
            ref_en_current <= onehot(src_idx);
            ref_en_old     <= onehot(spare_idx);
            busy           <= 1'b1;
          end else if (en) begin
            timer_r <= timer_r - TMR_W'(1);
          end else begin
            timer_r <= timer_r;
          end
        end
        START: begin
          state_r  <= COPY;
          start_SR <= {NUM_BANKS{1'b0}};
          wd_r     <= {WD_W{1'b0}};
        end
        COPY: begin
          // Completion takes priority over a watchdog expiring in the same cycle.
          if (done_s) begin
            state_r        <= SWAP;
            ref_en_current <= {NUM_BANKS{1'b0}};
            ref_en_old     <= {NUM_BANKS{1'b0}};
            swap           <= 1'b1;
          end else if (wd_r == WD_LAST) begin
            state_r        <= IDLE;
            ref_en_current <= {NUM_BANKS{1'b0}};
            ref_en_old     <= {NUM_BANKS{1'b0}};
            busy           <= 1'b0;
            err            <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        SWAP: begin
          state_r   <= IDLE;
          swap      <= 1'b0;
          busy      <= 1'b0;
          spare_idx <= src_idx;
          src_idx   <= next_src_s;
          timer_r   <= TMR_RELOAD;
        end
        default: begin
          state_r        <= IDLE;
          start_SR       <= {NUM_BANKS{1'b0}};
          ref_en_current <= {NUM_BANKS{1'b0}};
          ref_en_old     <= {NUM_BANKS{1'b0}};
          busy           <= 1'b0;
          swap           <= 1'b0;
        end
      endcase
    end
  end

endmodule
